// File: rtl/chess_pkg.sv
// Shared chess definitions: bitboard plane indices, square numbering, file masks
// and directional shift / sliding-ray helpers used by the move hardware.
package chess_pkg;

  localparam int BP = 0;
  localparam int BN = 1;
  localparam int BB = 2;
  localparam int BR = 3;
  localparam int BQ = 4;
  localparam int BK = 5;
  localparam int WP = 6;
  localparam int WN = 7;
  localparam int WB = 8;
  localparam int WR = 9;
  localparam int WQ = 10;
  localparam int WK = 11;

  localparam logic [63:0] NOT_A  = 64'hFEFE_FEFE_FEFE_FEFE;
  localparam logic [63:0] NOT_AB = 64'hFCFC_FCFC_FCFC_FCFC;
  localparam logic [63:0] NOT_H  = 64'h7F7F_7F7F_7F7F_7F7F;
  localparam logic [63:0] NOT_GH = 64'h3F3F_3F3F_3F3F_3F3F;

  function automatic logic [5:0] square(input logic [2:0] file, input logic [2:0] rank);
    return {rank, file};
  endfunction

  // Direction codes: 0 N, 1 S, 2 E, 3 W, 4 NE, 5 NW, 6 SE, 7 SW.
  function automatic logic [63:0] shift_dir(input logic [63:0] bb, input logic [2:0] dir);
    logic [63:0] r;
    case (dir)
      3'd0:    r = bb << 8;
      3'd1:    r = bb >> 8;
      3'd2:    r = (bb << 1) & NOT_A;
      3'd3:    r = (bb >> 1) & NOT_H;
      3'd4:    r = (bb << 9) & NOT_A;
      3'd5:    r = (bb << 7) & NOT_H;
      3'd6:    r = (bb >> 7) & NOT_A;
      default: r = (bb >> 9) & NOT_H;
    endcase
    return r;
  endfunction

  // Occluded fill through empty squares, then one more step so the first blocker is included.
  function automatic logic [63:0] ray_attacks(input logic [63:0] sliders, input logic [63:0] empty,
                                              input logic [2:0] dir);
    logic [63:0] flood;
    logic [63:0] gen;
    flood = sliders;
    gen   = sliders;
    for (int i = 0; i < 6; i++) begin
      gen   = shift_dir(gen, dir) & empty;
      flood = flood | gen;
    end
    return shift_dir(flood, dir);
  endfunction

endpackage

// File: rtl/attack_set.sv
// Combinational attack set for one colour: every square attacked by that colour's
// pieces in the given position, including occupied squares of either colour.
module attack_set
  import chess_pkg::*;
(
  input  logic [767:0] position,
  input  logic         is_white,
  output logic [63:0]  attacks
);

  logic [9:0]  base;
  logic [63:0] pawns, knights, bishops, rooks, queens, kings;
  logic [63:0] occ, empty, diag, orth;
  logic [63:0] pawn_att, knight_att, king_att, slide_att;

  always_comb begin
    base    = is_white ? 10'd384 : 10'd0;
    pawns   = position[base +: 64];
    knights = position[base + 10'd64 +: 64];
    bishops = position[base + 10'd128 +: 64];
    rooks   = position[base + 10'd192 +: 64];
    queens  = position[base + 10'd256 +: 64];
    kings   = position[base + 10'd320 +: 64];

    occ = '0;
    for (int p = 0; p < 12; p++) occ = occ | position[p*64 +: 64];
    empty = ~occ;
    diag  = bishops | queens;
    orth  = rooks | queens;

    if (is_white)
      pawn_att = ((pawns << 9) & NOT_A) | ((pawns << 7) & NOT_H);
    else
      pawn_att = ((pawns >> 7) & NOT_A) | ((pawns >> 9) & NOT_H);

    knight_att = ((knights << 17) & NOT_A)  | ((knights << 15) & NOT_H)
               | ((knights << 10) & NOT_AB) | ((knights << 6)  & NOT_GH)
               | ((knights >> 6)  & NOT_AB) | ((knights >> 10) & NOT_GH)
               | ((knights >> 15) & NOT_A)  | ((knights >> 17) & NOT_H);

    king_att = '0;
    for (int d = 0; d < 8; d++) king_att = king_att | shift_dir(kings, 3'(d));

    slide_att = '0;
    for (int d = 0; d < 4; d++) slide_att = slide_att | ray_attacks(orth, empty, 3'(d));
    for (int d = 4; d < 8; d++) slide_att = slide_att | ray_attacks(diag, empty, 3'(d));

    attacks = pawn_att | knight_att | king_att | slide_att;
  end

endmodule

// File: rtl/castling_unit.sv
// Registered castling validator/executor: checks a king move against the castling
// rules and emits the castled position, occupancy and both attack sets one cycle later.
module castling_unit
  import chess_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   old_file,
  input  logic [2:0]   old_rank,
  input  logic [2:0]   new_file,
  input  logic [2:0]   new_rank,
  input  logic         is_white,
  input  logic [767:0] position,
  output logic         castling_is_valid,
  output logic [767:0] castled,
  output logic [63:0]  all_castled,
  output logic [63:0]  white_attack_set,
  output logic [63:0]  black_attack_set
);

  logic [63:0]  white_att, black_att, occ, opp_att, all_d;
  logic [767:0] castled_d;
  logic         valid_d, ks_req, qs_req, ks_ok, qs_ok;
  logic [2:0]   home_rank;
  logic [9:0]   king_base, rook_base, row_base;
  logic [7:0]   king_row, rook_row, occ_row, att_row;

  attack_set u_white_att (.position(position), .is_white(1'b1), .attacks(white_att));
  attack_set u_black_att (.position(position), .is_white(1'b0), .attacks(black_att));

  always_comb begin
    occ = '0;
    for (int p = 0; p < 12; p++) occ = occ | position[p*64 +: 64];
  end

  // Rights are inferred purely from king and rook standing on their home squares.
  always_comb begin
    home_rank = is_white ? 3'd0 : 3'd7;
    king_base = is_white ? 10'(WK*64) : 10'(BK*64);
    rook_base = is_white ? 10'(WR*64) : 10'(BR*64);
    row_base  = {4'd0, square(3'd0, home_rank)};
    opp_att   = is_white ? black_att : white_att;

    king_row = position[king_base + row_base +: 8];
    rook_row = position[rook_base + row_base +: 8];
    occ_row  = occ[row_base[5:0] +: 8];
    att_row  = opp_att[row_base[5:0] +: 8];

    ks_req = (old_file == 3'd4) && (old_rank == home_rank) &&
             (new_file == 3'd6) && (new_rank == home_rank);
    qs_req = (old_file == 3'd4) && (old_rank == home_rank) &&
             (new_file == 3'd2) && (new_rank == home_rank);

    ks_ok = ks_req && king_row[4] && rook_row[7] && ~|occ_row[6:5] && ~|att_row[6:4];
    qs_ok = qs_req && king_row[4] && rook_row[0] && ~|occ_row[3:1] && ~|att_row[4:2];
    valid_d = ks_ok | qs_ok;

    castled_d = position;
    if (ks_ok) begin
      castled_d[king_base + row_base + 10'd4] = 1'b0;
      castled_d[king_base + row_base + 10'd6] = 1'b1;
      castled_d[rook_base + row_base + 10'd7] = 1'b0;
      castled_d[rook_base + row_base + 10'd5] = 1'b1;
    end
    if (qs_ok) begin
      castled_d[king_base + row_base + 10'd4] = 1'b0;
      castled_d[king_base + row_base + 10'd2] = 1'b1;
      castled_d[rook_base + row_base + 10'd0] = 1'b0;
      castled_d[rook_base + row_base + 10'd3] = 1'b1;
    end

    all_d = '0;
    for (int p = 0; p < 12; p++) all_d = all_d | castled_d[p*64 +: 64];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      castling_is_valid <= 1'b0;
      castled           <= '0;
      all_castled       <= '0;
      white_attack_set  <= '0;
      black_attack_set  <= '0;
    end else begin
      castling_is_valid <= valid_d;
      castled           <= castled_d;
      all_castled       <= all_d;
      white_attack_set  <= white_att;
      black_attack_set  <= black_att;
    end
  end

endmodule

// File: tb/tb_castling_unit.sv
// Bench for castling_unit: directed table of boards, reset/async-clear sequences,
// and random boards checked against a square-by-square reference model.
module tb_castling_unit;
  import chess_pkg::*;

  localparam int W = 961;  // {valid, castled, all_castled, white_att, black_att}

  localparam int KN_DF[8] = '{1, 2, 2, 1, -1, -2, -2, -1};
  localparam int KN_DR[8] = '{2, 1, -1, -2, -2, -1, 1, 2};
  localparam int DR_DF[8] = '{0, 0, 1, -1, 1, -1, 1, -1};
  localparam int DR_DR[8] = '{1, -1, 0, 0, 1, 1, -1, -1};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   old_file = '0, old_rank = '0, new_file = '0, new_rank = '0;
  logic         is_white = 1'b0;
  logic [767:0] position = '0;
  logic         castling_is_valid;
  logic [767:0] castled;
  logic [63:0]  all_castled, white_attack_set, black_attack_set;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int brd[64];

  typedef struct {
    logic [767:0] pos;
    logic         w;
    int           of, orr, nf, nr;
    logic         exp_valid;
  } vec_t;
  vec_t vecs[13];

  always #5 clk = ~clk;

  castling_unit dut (
    .clk(clk), .rst_n(rst_n),
    .old_file(old_file), .old_rank(old_rank), .new_file(new_file), .new_rank(new_rank),
    .is_white(is_white), .position(position),
    .castling_is_valid(castling_is_valid), .castled(castled), .all_castled(all_castled),
    .white_attack_set(white_attack_set), .black_attack_set(black_attack_set)
  );

  // ---------------- board construction ----------------
  task automatic clear_board();
    for (int i = 0; i < 64; i++) brd[i] = -1;
  endtask

  task automatic put(input int plane, input int f, input int r);
    brd[r*8 + f] = plane;
  endtask

  task automatic mv(input int f1, input int r1, input int f2, input int r2);
    brd[r2*8 + f2] = brd[r1*8 + f1];
    brd[r1*8 + f1] = -1;
  endtask

  function automatic logic [767:0] pack_board();
    logic [767:0] p = '0;
    for (int s = 0; s < 64; s++) if (brd[s] >= 0) p[brd[s]*64 + s] = 1'b1;
    return p;
  endfunction

  task automatic setup_start();
    int back[8] = '{3, 1, 2, 4, 5, 2, 1, 3};
    clear_board();
    for (int f = 0; f < 8; f++) begin
      put(6 + back[f], f, 0);
      put(WP, f, 1);
      put(BP, f, 6);
      put(back[f], f, 7);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit piece_at(logic [767:0] p, int plane, int f, int r);
    return p[plane*64 + r*8 + f];
  endfunction

  function automatic bit occ_at(logic [767:0] p, int f, int r);
    bit o = 0;
    for (int k = 0; k < 12; k++) o |= piece_at(p, k, f, r);
    return o;
  endfunction

  function automatic bit on_board(int f, int r);
    return f >= 0 && f < 8 && r >= 0 && r < 8;
  endfunction

  function automatic logic [63:0] m_attack(logic [767:0] p, bit w);
    logic [63:0] a = '0;
    int b = w ? 6 : 0;
    for (int s = 0; s < 64; s++) begin
      int f = s % 8;
      int r = s / 8;
      for (int k = 0; k < 6; k++) begin
        if (!p[(b + k)*64 + s]) continue;
        if (k == 0) begin
          int dr = w ? 1 : -1;
          if (on_board(f - 1, r + dr)) a[(r + dr)*8 + f - 1] = 1'b1;
          if (on_board(f + 1, r + dr)) a[(r + dr)*8 + f + 1] = 1'b1;
        end else if (k == 1) begin
          for (int d = 0; d < 8; d++)
            if (on_board(f + KN_DF[d], r + KN_DR[d])) a[(r + KN_DR[d])*8 + f + KN_DF[d]] = 1'b1;
        end else if (k == 5) begin
          for (int d = 0; d < 8; d++)
            if (on_board(f + DR_DF[d], r + DR_DR[d])) a[(r + DR_DR[d])*8 + f + DR_DF[d]] = 1'b1;
        end else begin
          int d0 = (k == 2) ? 4 : 0;
          int d1 = (k == 3) ? 3 : 7;
          for (int d = d0; d <= d1; d++) begin
            int tf = f;
            int tr = r;
            for (int step = 0; step < 7; step++) begin
              tf += DR_DF[d];
              tr += DR_DR[d];
              if (!on_board(tf, tr)) break;
              a[tr*8 + tf] = 1'b1;
              if (occ_at(p, tf, tr)) break;
            end
          end
        end
      end
    end
    return a;
  endfunction

  function automatic logic [767:0] castle_move(logic [767:0] p, bit w, bit kingside);
    int hr = w ? 0 : 7;
    int kp = w ? WK : BK;
    int rp = w ? WR : BR;
    p[kp*64 + hr*8 + 4] = 1'b0;
    p[kp*64 + hr*8 + (kingside ? 6 : 2)] = 1'b1;
    p[rp*64 + hr*8 + (kingside ? 7 : 0)] = 1'b0;
    p[rp*64 + hr*8 + (kingside ? 5 : 3)] = 1'b1;
    return p;
  endfunction

  function automatic bit m_valid(logic [767:0] p, bit w, int of, int orr, int nf, int nr);
    int hr = w ? 0 : 7;
    int kp = w ? WK : BK;
    int rp = w ? WR : BR;
    logic [63:0] opp = m_attack(p, !w);
    if (of != 4 || orr != hr || nr != hr) return 0;
    if (!piece_at(p, kp, 4, hr)) return 0;
    if (nf == 6)
      return piece_at(p, rp, 7, hr) && !occ_at(p, 5, hr) && !occ_at(p, 6, hr) &&
             !opp[hr*8 + 4] && !opp[hr*8 + 5] && !opp[hr*8 + 6];
    if (nf == 2)
      return piece_at(p, rp, 0, hr) && !occ_at(p, 1, hr) && !occ_at(p, 2, hr) &&
             !occ_at(p, 3, hr) && !opp[hr*8 + 4] && !opp[hr*8 + 3] && !opp[hr*8 + 2];
    return 0;
  endfunction

  function automatic logic [W-1:0] make_exp(logic [767:0] p, bit w, bit v, bit kingside);
    logic [767:0] c = v ? castle_move(p, w, kingside) : p;
    logic [63:0] all = '0;
    for (int k = 0; k < 12; k++) all |= c[k*64 +: 64];
    return {v, c, all, m_attack(p, 1'b1), m_attack(p, 1'b0)};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_out();
    logic [W-1:0] e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("valid", 768'(castling_is_valid), 768'(e[960]));
    chk("castled", castled, e[959:192]);
    chk("all_castled", 768'(all_castled), 768'(e[191:128]));
    chk("white_att", 768'(white_attack_set), 768'(e[127:64]));
    chk("black_att", 768'(black_attack_set), 768'(e[63:0]));
  endtask

  task automatic drive(input logic [767:0] p, input bit w, input int of, input int orr,
                       input int nf, input int nr, input logic [W-1:0] e);
    @(negedge clk);
    check_out();
    position = p;
    is_white = w;
    old_file = 3'(of);
    old_rank = 3'(orr);
    new_file = 3'(nf);
    new_rank = 3'(nr);
    exp_q.push_back(e);
  endtask

  task automatic flush();
    @(negedge clk);
    check_out();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 768'(castling_is_valid), '0);
    chk({tag, "_castled"}, castled, '0);
    chk({tag, "_all"}, 768'(all_castled), '0);
    chk({tag, "_watt"}, 768'(white_attack_set), '0);
    chk({tag, "_batt"}, 768'(black_attack_set), '0);
  endtask

  // ---------------- test ----------------
  logic [767:0] start_pos, blocked_pos, legal_k, legal_k_att, black_q, white_q,
                white_q_block, white_q_bfile, king_only;

  initial begin
    setup_start();
    start_pos = pack_board();
    mv(4, 1, 4, 3); mv(4, 6, 4, 4); mv(5, 0, 2, 3); mv(1, 7, 2, 5);
    mv(3, 0, 7, 4); mv(6, 7, 5, 5); mv(7, 4, 5, 6);
    blocked_pos = pack_board();

    clear_board(); put(WK, 4, 0); put(WR, 7, 0); put(BK, 4, 7);
    legal_k = pack_board();
    put(BR, 5, 7);
    legal_k_att = pack_board();
    clear_board(); put(BK, 4, 7); put(BR, 0, 7); put(WK, 4, 0);
    black_q = pack_board();
    clear_board(); put(WK, 4, 0); put(WR, 0, 0); put(BK, 7, 7);
    white_q = pack_board();
    put(WN, 1, 0);
    white_q_block = pack_board();
    brd[1] = -1; put(BR, 1, 7);
    white_q_bfile = pack_board();
    clear_board(); put(WK, 4, 0); put(BK, 4, 7);
    king_only = pack_board();

    vecs[0]  = '{start_pos, 1'b1, 4, 0, 6, 0, 1'b0};
    vecs[1]  = '{start_pos, 1'b1, 4, 0, 2, 0, 1'b0};
    vecs[2]  = '{start_pos, 1'b0, 4, 7, 6, 7, 1'b0};
    vecs[3]  = '{blocked_pos, 1'b1, 4, 0, 6, 0, 1'b0};
    vecs[4]  = '{legal_k, 1'b1, 4, 0, 6, 0, 1'b1};
    vecs[5]  = '{legal_k_att, 1'b1, 4, 0, 6, 0, 1'b0};
    vecs[6]  = '{black_q, 1'b0, 4, 7, 2, 7, 1'b1};
    vecs[7]  = '{legal_k, 1'b0, 4, 0, 6, 0, 1'b0};
    vecs[8]  = '{legal_k, 1'b1, 4, 0, 5, 0, 1'b0};
    vecs[9]  = '{white_q, 1'b1, 4, 0, 2, 0, 1'b1};
    vecs[10] = '{white_q_block, 1'b1, 4, 0, 2, 0, 1'b0};
    vecs[11] = '{white_q_bfile, 1'b1, 4, 0, 2, 0, 1'b1};
    vecs[12] = '{king_only, 1'b1, 4, 0, 6, 0, 1'b0};

    // Reset with the start position applied: everything reads zero.
    position = start_pos;
    is_white = 1'b1;
    old_file = 3'd4; new_file = 3'd6;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i])
      drive(vecs[i].pos, vecs[i].w, vecs[i].of, vecs[i].orr, vecs[i].nf, vecs[i].nr,
            make_exp(vecs[i].pos, vecs[i].w, vecs[i].exp_valid, vecs[i].nf == 6));
    flush();

    // Start-position attack sets against hand-derived constants.
    drive(start_pos, 1'b1, 0, 0, 0, 0, make_exp(start_pos, 1'b1, 1'b0, 1'b0));
    flush();
    chk("start_watt_const", 768'(white_attack_set), 768'(64'h0000_0000_00FF_FF7E));
    chk("start_batt_const", 768'(black_attack_set), 768'(64'h7EFF_FF00_0000_0000));

    // Legal white kingside: explicit plane values.
    drive(legal_k, 1'b1, 4, 0, 6, 0, make_exp(legal_k, 1'b1, 1'b1, 1'b1));
    flush();
    chk("wk_plane11", 768'(castled[WK*64 +: 64]), 768'(64'h40));
    chk("wk_plane9", 768'(castled[WR*64 +: 64]), 768'(64'h20));
    chk("wk_all", 768'(all_castled), 768'(64'h1000_0000_0000_0060));

    // Black queenside landing squares.
    drive(black_q, 1'b0, 4, 7, 2, 7, make_exp(black_q, 1'b0, 1'b1, 1'b0));
    flush();
    chk("bq_king_c8", 768'(castled[BK*64 +: 64]), 768'(64'h1 << 58));
    chk("bq_rook_d8", 768'(castled[BR*64 +: 64]), 768'(64'h1 << 59));

    // Back-to-back requests: each result follows its own inputs by exactly one cycle.
    drive(legal_k, 1'b1, 4, 0, 6, 0, make_exp(legal_k, 1'b1, 1'b1, 1'b1));
    drive(legal_k_att, 1'b1, 4, 0, 6, 0, make_exp(legal_k_att, 1'b1, 1'b0, 1'b1));
    drive(black_q, 1'b0, 4, 7, 2, 7, make_exp(black_q, 1'b0, 1'b1, 1'b0));
    flush();

    // Asynchronous reset between clock edges clears a held valid result immediately.
    drive(legal_k, 1'b1, 4, 0, 6, 0, make_exp(legal_k, 1'b1, 1'b1, 1'b1));
    @(posedge clk);
    #1;
    chk("pre_reset_valid", 768'(castling_is_valid), 768'(1));
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    check_zero("held_reset");
    rst_n = 1'b1;
    drive(legal_k, 1'b1, 4, 0, 6, 0, make_exp(legal_k, 1'b1, 1'b1, 1'b1));
    flush();

    // Random boards around the home squares.
    for (int it = 0; it < 300; it++) begin
      logic [767:0] p;
      bit w;
      int of, orr, nf, nr, mode, n;
      clear_board();
      if ($urandom_range(0, 5) != 0) put(WK, 4, 0); else put(WK, $urandom_range(0, 7), 2);
      if ($urandom_range(0, 5) != 0) put(BK, 4, 7); else put(BK, $urandom_range(0, 7), 5);
      if ($urandom_range(0, 3) != 0) put(WR, 7, 0);
      if ($urandom_range(0, 3) != 0) put(WR, 0, 0);
      if ($urandom_range(0, 3) != 0) put(BR, 7, 7);
      if ($urandom_range(0, 3) != 0) put(BR, 0, 7);
      n = $urandom_range(0, 5);
      for (int j = 0; j < n; j++) begin
        int s = $urandom_range(0, 63);
        int pl = $urandom_range(0, 11);
        if (pl == WK || pl == BK) pl = WQ;
        if (brd[s] < 0) brd[s] = pl;
      end
      p = pack_board();
      w = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 4);
      if (mode < 4) begin
        orr = w ? 0 : 7;
        of = 4;
        nr = orr;
        nf = (mode[0]) ? 6 : 2;
      end else begin
        of = $urandom_range(0, 7); orr = $urandom_range(0, 7);
        nf = $urandom_range(0, 7); nr = $urandom_range(0, 7);
      end
      drive(p, w, of, orr, nf, nr, make_exp(p, w, m_valid(p, w, of, orr, nf, nr), nf == 6));
    end
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
